// File: rtl/bsg_fifo_1r1w_rolly_count.sv
// Speculative FIFO with a read checkpoint (rcptr) and a write commit pointer
// (wcptr). It can retire several read entries per cycle, reports occupancy,
// raises a programmable almost-full flag and latches a sticky over-dequeue
// error. Pointers carry a lap bit and use modulo 2*els_p arithmetic, so
// els_p does not have to be a power of two.
module bsg_fifo_1r1w_rolly_count #(
    parameter int width_p              = 8,
    parameter int els_p                = 4,
    parameter int deq_max_p            = 1,
    parameter int almost_full_thresh_p = els_p - 1,
    parameter int ready_THEN_valid_p   = 0,
    localparam int cnt_w               = $clog2(els_p + 1),
    localparam int deq_w               = $clog2(deq_max_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clr_v_i,
    input  logic               deq_v_i,
    input  logic [deq_w-1:0]   deq_cnt_i,
    input  logic               rollback_v_i,
    input  logic               commit_not_drop_v_i,
    input  logic               commit_not_drop_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic [cnt_w-1:0]   avail_cnt_o,
    output logic [cnt_w-1:0]   used_cnt_o,
    output logic               almost_full_o,
    output logic               deq_err_o
);

    localparam int pw = $clog2(2 * els_p);
    localparam int ew = pw + 1;
    localparam int iw = $clog2(els_p);
    localparam logic [ew-1:0] span = ew'(2 * els_p);

    // Advance a pointer by n slots, wrapping at 2*els_p.
    function automatic logic [pw-1:0] ptr_add(input logic [pw-1:0] p, input logic [pw-1:0] n);
        logic [ew-1:0] s;
        s = {1'b0, p} + {1'b0, n};
        if (s >= span) s = s - span;
        return s[pw-1:0];
    endfunction

    // Forward distance from b to a, always in 0..els_p for legal states.
    function automatic logic [pw-1:0] ptr_dist(input logic [pw-1:0] a, input logic [pw-1:0] b);
        logic [ew-1:0] d;
        if (a >= b) d = {1'b0, a} - {1'b0, b};
        else        d = {1'b0, a} + span - {1'b0, b};
        return d[pw-1:0];
    endfunction

    // Strip the lap from a pointer to get the storage slot.
    function automatic logic [iw-1:0] ptr_idx(input logic [pw-1:0] p);
        logic [pw-1:0] i;
        i = (p >= pw'(els_p)) ? p - pw'(els_p) : p;
        return i[iw-1:0];
    endfunction

    logic [width_p-1:0] mem [els_p];

    logic [pw-1:0] rptr, rcptr, wptr, wcptr;
    logic [pw-1:0] rptr_n, rcptr_n, wptr_n, wcptr_n;
    logic [pw-1:0] rd_dist, used, avail, eff_cnt;
    logic          drop, commit, enq, yumi_eff, over_deq;

    assign rd_dist = ptr_dist(rptr, rcptr);
    assign used    = ptr_dist(wptr, rcptr);
    assign avail   = ptr_dist(wcptr, rptr);

    assign drop     = commit_not_drop_v_i & ~commit_not_drop_i;
    assign commit   = commit_not_drop_v_i & commit_not_drop_i;
    assign over_deq = deq_v_i & (int'(deq_cnt_i) > int'(rd_dist));

    assign ready_o  = ~clr_v_i & ~drop & (int'(used) < els_p);
    assign enq      = (ready_THEN_valid_p != 0) ? v_i : (v_i & ready_o);
    assign v_o      = ~rollback_v_i & (avail != '0);
    assign yumi_eff = yumi_i & v_o;

    assign data_o        = mem[ptr_idx(rptr)];
    assign avail_cnt_o   = cnt_w'(avail);
    assign used_cnt_o    = cnt_w'(used);
    assign almost_full_o = (int'(used) >= almost_full_thresh_p);

    // Retire only what was read before this cycle; excess requests are clipped.
    always_comb begin
        eff_cnt = '0;
        if (deq_v_i) begin
            if (over_deq) eff_cnt = rd_dist;
            else          eff_cnt = pw'(deq_cnt_i);
        end
    end

    // Next pointer values: clr beats commit/drop, rollback beats yumi.
    always_comb begin
        rcptr_n = ptr_add(rcptr, eff_cnt);
        rptr_n  = rptr;
        wptr_n  = wptr;
        wcptr_n = wcptr;
        if (rollback_v_i)  rptr_n = rcptr_n;
        else if (yumi_eff) rptr_n = ptr_add(rptr, pw'(1));
        if (clr_v_i)       wptr_n = rptr_n;
        else if (drop)     wptr_n = wcptr;
        else if (enq)      wptr_n = ptr_add(wptr, pw'(1));
        if (clr_v_i)       wcptr_n = rptr_n;
        else if (commit)   wcptr_n = ptr_add(wptr, pw'(enq));
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr  <= '0;
            rcptr <= '0;
            wptr  <= '0;
            wcptr <= '0;
        end else begin
            rptr  <= rptr_n;
            rcptr <= rcptr_n;
            wptr  <= wptr_n;
            wcptr <= wcptr_n;
        end
    end

    // Storage write at the uncommitted write pointer.
    always_ff @(posedge clk_i) begin
        if (enq) mem[ptr_idx(wptr)] <= data_i;
    end

    // Sticky over-dequeue flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i)       deq_err_o <= 1'b0;
        else if (over_deq) deq_err_o <= 1'b1;
    end

endmodule

// File: tb/tb_bsg_fifo_1r1w_rolly_count.sv
// Bench for the rolly FIFO: a 4-entry and a 3-entry instance share inputs;
// a queue-style model tracks both, and a hand-derived vector table checks
// the 4-entry instance.
module tb_bsg_fifo_1r1w_rolly_count;

    logic       clk = 1'b0;
    logic       reset, clr_v, deq_v, rollback_v, cnd_v, cnd, v_in, yumi;
    logic [1:0] deq_cnt;
    logic [7:0] data_in;

    logic       ready4, v_o4, af4, err4;
    logic [7:0] data4;
    logic [2:0] avail4, used4;
    logic       ready3, v_o3, af3, err3;
    logic [7:0] data3;
    logic [1:0] avail3, used3;

    int n_pass  = 0;
    int n_total = 0;

    // Model: entries listed from the read checkpoint onward.
    logic [7:0] mq [2][8];
    int msz [2], mrd [2], mcm [2];
    bit merr [2];
    int cap [2] = '{4, 3};

    typedef struct {
        logic clr, deq;
        logic [1:0] cnt;
        logic rb, cv, c, v, y;
        logic [7:0] d;
        logic e_v;
        logic [7:0] e_data;
        logic e_ready;
        int e_avail, e_used;
        logic e_af, e_err;
    } vec_t;

    vec_t vecs [31];

    always #5 clk = ~clk;

    bsg_fifo_1r1w_rolly_count #(.width_p(8), .els_p(4), .deq_max_p(2)) dut4 (
        .clk_i(clk), .reset_i(reset), .clr_v_i(clr_v), .deq_v_i(deq_v),
        .deq_cnt_i(deq_cnt), .rollback_v_i(rollback_v),
        .commit_not_drop_v_i(cnd_v), .commit_not_drop_i(cnd),
        .data_i(data_in), .v_i(v_in), .ready_o(ready4), .data_o(data4),
        .v_o(v_o4), .yumi_i(yumi), .avail_cnt_o(avail4), .used_cnt_o(used4),
        .almost_full_o(af4), .deq_err_o(err4));

    bsg_fifo_1r1w_rolly_count #(.width_p(8), .els_p(3), .deq_max_p(2)) dut3 (
        .clk_i(clk), .reset_i(reset), .clr_v_i(clr_v), .deq_v_i(deq_v),
        .deq_cnt_i(deq_cnt), .rollback_v_i(rollback_v),
        .commit_not_drop_v_i(cnd_v), .commit_not_drop_i(cnd),
        .data_i(data_in), .v_i(v_in), .ready_o(ready3), .data_o(data3),
        .v_o(v_o3), .yumi_i(yumi), .avail_cnt_o(avail3), .used_cnt_o(used3),
        .almost_full_o(af3), .deq_err_o(err3));

    function automatic vec_t mk(input logic clr, deq, input logic [1:0] cnt,
                                input logic rb, cv, c, v, y, input logic [7:0] d,
                                input logic e_v, input logic [7:0] e_data, input logic e_ready,
                                input int e_avail, e_used, input logic e_af, e_err);
        vec_t t;
        t.clr = clr; t.deq = deq; t.cnt = cnt; t.rb = rb; t.cv = cv; t.c = c;
        t.v = v; t.y = y; t.d = d; t.e_v = e_v; t.e_data = e_data;
        t.e_ready = e_ready; t.e_avail = e_avail; t.e_used = e_used;
        t.e_af = e_af; t.e_err = e_err;
        return t;
    endfunction

    function automatic bit m_v(input int k);
        return !rollback_v && (mcm[k] - mrd[k] > 0);
    endfunction

    function automatic bit m_ready(input int k);
        return !clr_v && !(cnd_v && !cnd) && (msz[k] < cap[k]);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            msz[k] = 0; mrd[k] = 0; mcm[k] = 0; merr[k] = 0;
        end
    endtask

    task automatic m_step(input int k);
        bit over, yum, enq;
        int eff, rdn;
        over = deq_v && (int'(deq_cnt) > mrd[k]);
        eff  = deq_v ? (over ? mrd[k] : int'(deq_cnt)) : 0;
        yum  = yumi && m_v(k);
        enq  = v_in && m_ready(k);
        if (over) merr[k] = 1;
        for (int e = 0; e < eff; e++) begin
            for (int j = 0; j < 7; j++) mq[k][j] = mq[k][j+1];
            msz[k]--;
        end
        mrd[k] -= eff;
        mcm[k] -= eff;
        rdn = rollback_v ? 0 : mrd[k] + int'(yum);
        mrd[k] = rdn;
        if (clr_v) begin
            msz[k] = rdn;
            mcm[k] = rdn;
        end else if (cnd_v && !cnd) begin
            msz[k] = mcm[k];
        end else begin
            if (enq) begin
                mq[k][msz[k]] = data_in;
                msz[k]++;
            end
            if (cnd_v && cnd) mcm[k] = msz[k];
        end
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic apply_stimulus(input vec_t t);
        @(negedge clk);
        clr_v = t.clr; deq_v = t.deq; deq_cnt = t.cnt; rollback_v = t.rb;
        cnd_v = t.cv; cnd = t.c; v_in = t.v; yumi = t.y; data_in = t.d;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic a_v, a_r, a_af, a_err;
        logic [7:0] a_d;
        int a_av, a_us;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                a_v = v_o4; a_d = data4; a_r = ready4; a_av = int'(avail4);
                a_us = int'(used4); a_af = af4; a_err = err4;
            end else begin
                a_v = v_o3; a_d = data3; a_r = ready3; a_av = int'(avail3);
                a_us = int'(used3); a_af = af3; a_err = err3;
            end
            check_output($sformatf("%s e%0d v_o", tag, cap[k]), int'(a_v), int'(m_v(k)));
            if (m_v(k))
                check_output($sformatf("%s e%0d data_o", tag, cap[k]), int'(a_d), int'(mq[k][mrd[k]]));
            check_output($sformatf("%s e%0d ready_o", tag, cap[k]), int'(a_r), int'(m_ready(k)));
            check_output($sformatf("%s e%0d avail", tag, cap[k]), a_av, mcm[k] - mrd[k]);
            check_output($sformatf("%s e%0d used", tag, cap[k]), a_us, msz[k]);
            check_output($sformatf("%s e%0d almost_full", tag, cap[k]), int'(a_af), int'(msz[k] >= cap[k] - 1));
            check_output($sformatf("%s e%0d deq_err", tag, cap[k]), int'(a_err), int'(merr[k]));
        end
    endtask

    task automatic end_cycle();
        @(posedge clk);
        if (reset) m_reset();
        else for (int k = 0; k < 2; k++) m_step(k);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " v_o"}, int'(v_o4), 0);
        check_output({tag, " ready_o"}, int'(ready4), 1);
        check_output({tag, " avail"}, int'(avail4), 0);
        check_output({tag, " used"}, int'(used4), 0);
        check_output({tag, " almost_full"}, int'(af4), 0);
        check_output({tag, " deq_err"}, int'(err4), 0);
    endtask

    initial begin
        vec_t t;
        reset = 1'b1; clr_v = 0; deq_v = 0; deq_cnt = 0; rollback_v = 0;
        cnd_v = 0; cnd = 0; v_in = 0; yumi = 0; data_in = 0;
        m_reset();

        //          clr deq cnt rb cv c  v  y  d       e_v data   rdy av us af err
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 8'hA1,  0, 8'h00, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 8'hB2,  0, 8'h00, 1, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 1, 1, 1, 0, 8'hC3,  0, 8'h00, 1, 0, 2, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 1, 1, 1, 0, 8'hD4,  1, 8'hA1, 1, 3, 3, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00,  1, 8'hA1, 0, 4, 4, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00,  1, 8'hB2, 0, 3, 4, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00,  1, 8'hC3, 0, 2, 4, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00,  1, 8'hD4, 0, 1, 4, 1, 0);
        vecs[8]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 4, 1, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00,  1, 8'hA1, 0, 4, 4, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00,  1, 8'hB2, 0, 3, 4, 1, 0);
        vecs[11] = mk(0, 1, 2, 1, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 2, 4, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 8'hE5,  1, 8'hC3, 1, 2, 2, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 8'hF6,  1, 8'hC3, 1, 2, 3, 1, 0);
        vecs[14] = mk(0, 0, 0, 0, 1, 0, 0, 0, 8'h00,  1, 8'hC3, 0, 2, 4, 1, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00,  1, 8'hC3, 1, 2, 2, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00,  1, 8'hD4, 1, 1, 2, 0, 0);
        vecs[17] = mk(0, 1, 2, 0, 0, 0, 0, 0, 8'h00,  0, 8'h00, 1, 0, 2, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h07,  0, 8'h00, 1, 0, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h08,  0, 8'h00, 1, 0, 1, 0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 0, 8'h09,  0, 8'h00, 1, 0, 2, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 1, 1, 1, 0, 8'h0A,  0, 8'h00, 1, 0, 3, 1, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00,  1, 8'h07, 0, 4, 4, 1, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00,  1, 8'h07, 0, 4, 4, 1, 0);
        vecs[24] = mk(0, 1, 1, 0, 0, 0, 0, 0, 8'h00,  1, 8'h08, 0, 3, 4, 1, 0);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00,  1, 8'h08, 1, 3, 3, 1, 0);
        vecs[26] = mk(0, 1, 2, 0, 0, 0, 0, 0, 8'h00,  1, 8'h09, 1, 2, 3, 1, 0);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00,  1, 8'h09, 1, 2, 2, 0, 1);
        vecs[28] = mk(1, 0, 0, 0, 0, 0, 1, 1, 8'hEE,  1, 8'h09, 0, 2, 2, 0, 1);
        vecs[29] = mk(1, 0, 0, 1, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 1, 0, 1);
        vecs[30] = mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00,  0, 8'h00, 1, 0, 0, 0, 1);

        // Reset state, observed while reset is still held.
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Directed table on the 4-entry instance, model on both.
        for (int i = 0; i < 31; i++) begin
            t = vecs[i];
            apply_stimulus(t);
            check_output($sformatf("row%0d v_o", i), int'(v_o4), int'(t.e_v));
            if (t.e_v) check_output($sformatf("row%0d data_o", i), int'(data4), int'(t.e_data));
            check_output($sformatf("row%0d ready_o", i), int'(ready4), int'(t.e_ready));
            check_output($sformatf("row%0d avail", i), int'(avail4), t.e_avail);
            check_output($sformatf("row%0d used", i), int'(used4), t.e_used);
            check_output($sformatf("row%0d almost_full", i), int'(af4), int'(t.e_af));
            check_output($sformatf("row%0d deq_err", i), int'(err4), int'(t.e_err));
            check_model($sformatf("row%0d", i));
            end_cycle();
        end

        // Streaming across several laps: enq+commit, yumi and deq 1 every cycle.
        for (int i = 0; i < 12; i++) begin
            t = mk(0, 1, 1, 0, 1, 1, 1, 1, 8'(8'h30 + i), 0, 8'h00, 0, 0, 0, 0, 0);
            apply_stimulus(t);
            check_model($sformatf("wrap%0d", i));
            end_cycle();
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            t = mk(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 3),
                   2'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                   8'($urandom), 0, 8'h00, 0, 0, 0, 0, 0);
            apply_stimulus(t);
            check_model($sformatf("rand%0d", i));
            end_cycle();
        end

        // Mid-operation reset must clear contents and the sticky error.
        for (int i = 0; i < 2; i++) begin
            t = mk(0, 0, 0, 0, 1, 1, 1, 0, 8'(8'h50 + i), 0, 8'h00, 0, 0, 0, 0, 0);
            apply_stimulus(t);
            check_model($sformatf("pre_rst%0d", i));
            end_cycle();
        end
        @(negedge clk);
        reset = 1'b1; clr_v = 0; deq_v = 0; deq_cnt = 0; rollback_v = 0;
        cnd_v = 0; cnd = 0; v_in = 0; yumi = 0;
        end_cycle();
        @(negedge clk); #1;
        check_reset_values("midrst");
        check_model("midrst");
        reset = 1'b0;

        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
